muldiv_unit: RTL and testbench

Iterative multiply/divide unit that sits directly downstream of the instruction decoder, alongside the ALU. It consumes the decoder's two register operands (rs, rt) plus the instruction function field, executes MULT/MULTU/DIV/DIVU over multiple cycles, and owns the architectural HI/LO registers. MFHI/MFLO results return to the register-file write-back path; the `stall` output freezes fetch/decode while an operation is in flight.

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_unit #(
  parameter logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        md_start,
  input  logic [5:0]  Function_opcode,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  output logic [31:0] md_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  iter_cnt;
  logic [63:0] acc;
  logic [31:0] divisor_mag;
  logic [31:0] dividend_raw;
  logic        op_div;
  logic        neg_lo;
  logic        neg_hi;
  logic        div_zero;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept, start_op, signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign busy   = (state != S_IDLE);
  assign stall  = busy && md_start;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign done   = done_q;

  assign accept    = md_start && !busy;
  assign start_op  = accept && (Function_opcode[5:2] == 4'b0110);
  // MULT and DIV are the even funct codes; MULTU/DIVU the odd ones
  assign signed_op = !Function_opcode[0];
  assign a_neg     = signed_op && read_data_1[31];
  assign b_neg     = signed_op && read_data_2[31];
  assign a_mag     = a_neg ? -read_data_1 : read_data_1;
  assign b_mag     = b_neg ? -read_data_2 : read_data_2;

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor_mag} : 33'd0);
  assign div_diff = acc[63:31] - {1'b0, divisor_mag};
  assign acc_step = !op_div       ? {mul_sum, acc[31:1]} :
                    div_diff[32]  ? {acc[62:0], 1'b0} :
                                    {div_diff[31:0], acc[30:0], 1'b1};

  assign prod_fix = neg_lo ? -acc : acc;
  assign quot_fix = neg_lo ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_hi ? -acc[63:32] : acc[63:32];

  always_comb begin
    md_result = 32'd0;
    if (md_start) begin
      if (Function_opcode == F_MFHI) md_result = hi_q;
      else if (Function_opcode == F_MFLO) md_result = lo_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_op) state_nxt = S_CALC;
      S_CALC:  if (iter_cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      iter_cnt     <= 5'd0;
      acc          <= 64'd0;
      divisor_mag  <= 32'd0;
      dividend_raw <= 32'd0;
      op_div       <= 1'b0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      div_zero     <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && Function_opcode == F_MTHI) hi_q <= read_data_1;
          if (accept && Function_opcode == F_MTLO) lo_q <= read_data_1;
          if (start_op) begin
            iter_cnt     <= 5'd0;
            acc          <= {32'd0, a_mag};
            divisor_mag  <= b_mag;
            dividend_raw <= read_data_1;
            op_div       <= Function_opcode[1];
            neg_lo       <= a_neg ^ b_neg;
            neg_hi       <= a_neg;
            div_zero     <= (read_data_2 == 32'd0);
          end
        end
        S_CALC: begin
          acc      <= acc_step;
          iter_cnt <= iter_cnt + 5'd1;
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (!op_div) begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end else if (div_zero) begin
            hi_q <= dividend_raw;
            lo_q <= DIV0_QUOTIENT;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        md_start = 1'b0;
  logic [5:0]  Function_opcode = 6'd0;
  logic [31:0] read_data_1 = 32'd0;
  logic [31:0] read_data_2 = 32'd0;
  logic [31:0] md_result, hi, lo;
  logic        busy, done, stall;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .md_start(md_start),
    .Function_opcode(Function_opcode), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .md_result(md_result), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain language arithmetic plus the two architectural special cases
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml);
    int          sa, sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    mh = 32'd0;
    ml = 32'd0;
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        up = sp;
        mh = up[63:32];
        ml = up[31:0];
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        mh = up[63:32];
        ml = up[31:0];
      end
      F_DIV: begin
        if (b == 32'd0) begin
          mh = a; ml = 32'hFFFFFFFF;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          mh = 32'd0; ml = 32'h80000000;
        end else begin
          mh = sa % sb; ml = sa / sb;
        end
      end
      F_DIVU: begin
        if (b == 32'd0) begin
          mh = a; ml = 32'hFFFFFFFF;
        end else begin
          mh = a % b; ml = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one op, check 33-cycle busy window, single done pulse and HI/LO stability
  task automatic do_op(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] rh, output logic [31:0] rl);
    int          cyc;
    logic        stable;
    logic [31:0] old_hi, old_lo;
    @(negedge clock);
    old_hi = hi;
    old_lo = lo;
    md_start = 1'b1; Function_opcode = f; read_data_1 = a; read_data_2 = b;
    @(negedge clock);
    md_start = 1'b0;
    cyc = 0;
    stable = 1'b1;
    while (busy && cyc < 40) begin
      if (hi !== old_hi || lo !== old_lo || done !== 1'b0) stable = 1'b0;
      cyc++;
      @(negedge clock);
    end
    check({name, " busy_cycles"}, cyc, 33);
    check({name, " hilo_stable"}, {31'd0, stable}, 32'd1);
    check({name, " done_pulse"}, {31'd0, done}, 32'd1);
    rh = hi;
    rl = lo;
    @(negedge clock);
    check({name, " done_single"}, {31'd0, done}, 32'd0);
  endtask

  vec_t        vecs[$];
  logic [31:0] rh, rl, mh, ml, a, b;
  logic [5:0]  f;
  logic        stall_ok;
  int          cyc;

  initial begin
    vecs.push_back('{"mult_neg3x5",   F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"multu_max_x2",  F_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{"mult_min_sq",   F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"div_neg7_2",    F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_7_neg2",    F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{"divu_7_2",      F_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003});
    vecs.push_back('{"div_overflow",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{"divu_by_zero",  F_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF});
    vecs.push_back('{"div_by_zero",   F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    // MTHI / MTLO / MFHI / unknown funct
    md_start = 1'b1; Function_opcode = F_MTHI; read_data_1 = 32'h12345678;
    @(negedge clock);
    check("mthi", hi, 32'h12345678);
    Function_opcode = F_MTLO; read_data_1 = 32'h9ABCDEF0;
    @(negedge clock);
    check("mtlo", lo, 32'h9ABCDEF0);
    check("mtlo_keeps_hi", hi, 32'h12345678);
    Function_opcode = F_MFHI;
    #1 check("mfhi_comb", md_result, 32'h12345678);
    Function_opcode = F_MFLO;
    #1 check("mflo_comb", md_result, 32'h9ABCDEF0);
    Function_opcode = 6'b100000; read_data_1 = 32'hDEADBEEF;
    #1 check("other_funct_result", md_result, 32'd0);
    @(negedge clock);
    check("other_funct_hi", hi, 32'h12345678);
    check("other_funct_lo", lo, 32'h9ABCDEF0);
    check("other_funct_busy", {31'd0, busy}, 32'd0);
    md_start = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, rh, rl);
      check({vecs[i].name, " hi"}, rh, vecs[i].exp_hi);
      check({vecs[i].name, " lo"}, rl, vecs[i].exp_lo);
    end

    // Randomised ops against the reference model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b & 32'hFF;
        2: a = a & 32'hFFFF;
        3: b = -($urandom_range(1, 9));
        default: ;
      endcase
      model(f, a, b, mh, ml);
      do_op($sformatf("rand%0d", n), f, a, b, rh, rl);
      check($sformatf("rand%0d hi", n), rh, mh);
      check($sformatf("rand%0d lo", n), rl, ml);
    end

    // Stall: second MULT and then MFLO presented while busy
    @(negedge clock);
    md_start = 1'b1; Function_opcode = F_MULTU; read_data_1 = 32'h00001234; read_data_2 = 32'h00005678;
    @(negedge clock);
    Function_opcode = F_MULT; read_data_1 = 32'd3; read_data_2 = 32'd3;
    cyc = 0;
    stall_ok = 1'b1;
    while (busy && cyc < 40) begin
      if (cyc == 4) Function_opcode = F_MFLO;
      #1;
      if (stall !== 1'b1) stall_ok = 1'b0;
      cyc++;
      @(negedge clock);
    end
    check("stall_busy_cycles", cyc, 33);
    check("stall_held", {31'd0, stall_ok}, 32'd1);
    #1;
    check("stall_release", {31'd0, stall}, 32'd0);
    check("stall_mflo_result", md_result, 32'h0626_0060);
    check("stall_hi", hi, 32'd0);
    md_start = 1'b0;
    @(negedge clock);
    check("stall_no_restart", {31'd0, busy}, 32'd0);

    // Reset during CALC aborts without a partial HI/LO write
    md_start = 1'b1; Function_opcode = F_MULT; read_data_1 = 32'd1000; read_data_2 = 32'd1000;
    @(negedge clock);
    md_start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    stall_ok = 1'b1;
    repeat (30) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) stall_ok = 1'b0;
    end
    check("abort_no_done", {31'd0, stall_ok}, 32'd1);
    do_op("after_abort", F_MULT, 32'd6, 32'd7, rh, rl);
    check("after_abort hi", rh, 32'd0);
    check("after_abort lo", rl, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
